// File: rtl/mp2_audio_pkg.sv
// Shared definitions for the MP2 decoder audio output path.
//
// Holds the sample-reader FSM encoding and the location of the PCM
// ping-pong region inside the 1024x16 sample buffer. The filterbank
// writer uses the same constants, so both sides agree on the layout.
package mp2_audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_L    = 3'd1,
    ST_RD_R    = 3'd2,
    ST_CAP_R   = 3'd3,
    ST_PRESENT = 3'd4,
    ST_RELEASE = 3'd5
  } rd_state_e;

  // First word of the ping-pong region and words per half.
  // Each half holds interleaved L/R words, so HALF_LEN/2 stereo pairs.
  localparam logic [9:0] SAMPLE_BUF_BASE = 10'h280;
  localparam int         SAMPLE_HALF_LEN = 64;

endpackage

// File: rtl/pcm_sample_reader.sv
// pcm_sample_reader
//
// Drain side of the decoder sample buffer. Waits for the producer to mark
// a half as full, reads its interleaved L/R words through a registered-read
// RAM port, presents them as stereo pairs on a valid/ready handshake and
// hands the half back to the producer once every pair has been accepted.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   Fill_Done_I/_Half_I  producer pulse: half Fill_Half_I is now full
//   Release_O/_Half_O    pulse: half Release_Half_O is free for refill
//   RAM_Address_O/_Ren_O read port address and enable
//   RAM_Data_I           read data, one cycle after the address
//   Sample_Left_O/_Right_O, Sample_Valid_O, Sample_Ready_I
//                        stereo pair handshake towards the codec transmitter
//   Overflow_O           pulse: fill of a half that was still full
//   Underrun_O           pulse: transmitter ready with nothing to play
module pcm_sample_reader
  import mp2_audio_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] BUF_BASE = ADDR_W'(SAMPLE_BUF_BASE),
  parameter int                HALF_LEN = SAMPLE_HALF_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Fill_Done_I,
  input  logic              Fill_Half_I,
  output logic              Release_O,
  output logic              Release_Half_O,
  output logic [ADDR_W-1:0] RAM_Address_O,
  output logic              RAM_Ren_O,
  input  logic [DATA_W-1:0] RAM_Data_I,
  output logic [DATA_W-1:0] Sample_Left_O,
  output logic [DATA_W-1:0] Sample_Right_O,
  output logic              Sample_Valid_O,
  input  logic              Sample_Ready_I,
  output logic              Overflow_O,
  output logic              Underrun_O
);

  localparam int PAIRS = HALF_LEN / 2;
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

  rd_state_e         state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              play_half_q, play_half_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              started_q, started_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              udr_q, udr_d;
  logic              ren;
  logic              rel;
  logic [ADDR_W-1:0] pair_addr;

  // Address of the left word of the current pair; the right word follows it.
  assign pair_addr = BUF_BASE
                   + (play_half_q ? ADDR_W'(HALF_LEN) : '0)
                   + ADDR_W'({idx_q, 1'b0});

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    play_half_d = play_half_q;
    idx_d       = idx_q;
    started_d   = started_q;
    addr_d      = addr_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    ovf_d       = 1'b0;
    udr_d       = 1'b0;
    ren         = 1'b0;
    rel         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (full_q[play_half_q]) begin
          state_d = ST_RD_L;
        end else if (started_q && Sample_Ready_I) begin
          // Nothing is advanced here: playback simply waits for the fill.
          udr_d = 1'b1;
        end
      end
      ST_RD_L: begin
        ren     = 1'b1;
        addr_d  = pair_addr;
        state_d = ST_RD_R;
      end
      ST_RD_R: begin
        // Read data of the L address issued in the previous cycle.
        ren         = 1'b1;
        addr_d      = pair_addr + ADDR_W'(1);
        left_hold_d = RAM_Data_I;
        state_d     = ST_CAP_R;
      end
      ST_CAP_R: begin
        // Both words land in the output registers together so the pair
        // never changes while it is being presented.
        left_d  = left_hold_q;
        right_d = RAM_Data_I;
        valid_d = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (Sample_Ready_I) begin
          valid_d   = 1'b0;
          started_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_RELEASE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RD_L;
          end
        end
      end
      ST_RELEASE: begin
        rel                 = 1'b1;
        full_d[play_half_q] = 1'b0;
        play_half_d         = ~play_half_q;
        idx_d               = '0;
        state_d             = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the release clear so a same-cycle refill of the half
    // being released keeps it marked full. That refill is legitimate, so
    // it is not reported as an overflow.
    if (Fill_Done_I) begin
      ovf_d = full_q[Fill_Half_I] && !(rel && (Fill_Half_I == play_half_q));
      full_d[Fill_Half_I] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      full_q      <= '0;
      play_half_q <= 1'b0;
      idx_q       <= '0;
      started_q   <= 1'b0;
      addr_q      <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      play_half_q <= play_half_d;
      idx_q       <= idx_d;
      started_q   <= started_d;
      addr_q      <= addr_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      udr_q       <= udr_d;
    end
  end

  // The address is driven directly in the read states and otherwise holds
  // the last address issued.
  assign RAM_Address_O  = addr_d;
  assign RAM_Ren_O      = ren;
  assign Release_O      = rel;
  assign Release_Half_O = rel & play_half_q;
  assign Sample_Left_O  = left_q;
  assign Sample_Right_O = right_q;
  assign Sample_Valid_O = valid_q;
  assign Overflow_O     = ovf_q;
  assign Underrun_O     = udr_q;

endmodule

// File: tb/tb_pcm_sample_reader.sv
module tb_pcm_sample_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        Fill_Done_I;
  logic        Fill_Half_I;
  logic        Release_O;
  logic        Release_Half_O;
  logic [9:0]  RAM_Address_O;
  logic        RAM_Ren_O;
  logic [15:0] RAM_Data_I;
  logic [15:0] Sample_Left_O;
  logic [15:0] Sample_Right_O;
  logic        Sample_Valid_O;
  logic        Sample_Ready_I;
  logic        Overflow_O;
  logic        Underrun_O;

  int n_checks = 0;
  int n_fail   = 0;

  pcm_sample_reader dut (
    .clock          (clock),
    .reset          (reset),
    .Fill_Done_I    (Fill_Done_I),
    .Fill_Half_I    (Fill_Half_I),
    .Release_O      (Release_O),
    .Release_Half_O (Release_Half_O),
    .RAM_Address_O  (RAM_Address_O),
    .RAM_Ren_O      (RAM_Ren_O),
    .RAM_Data_I     (RAM_Data_I),
    .Sample_Left_O  (Sample_Left_O),
    .Sample_Right_O (Sample_Right_O),
    .Sample_Valid_O (Sample_Valid_O),
    .Sample_Ready_I (Sample_Ready_I),
    .Overflow_O     (Overflow_O),
    .Underrun_O     (Underrun_O)
  );

  always #5 clock = ~clock;

  // Registered-read sample buffer model.
  logic [15:0] mem [0:1023];
  always @(posedge clock) begin
    if (RAM_Ren_O) RAM_Data_I <= mem[RAM_Address_O];
  end

  // Observations gathered by collect(); the test tasks judge them.
  int          c_pairs, c_rel, c_first_ren, c_first_vld, c_ovf, c_udr, c_ren;
  logic [9:0]  c_first_addr;
  logic        c_rel_half [0:3];
  int          c_rel_pair [0:3];
  logic [15:0] got_l [0:127];
  logic [15:0] got_r [0:127];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Fill_Done_I = 1'b0;
    Fill_Half_I = 1'b0;
    Sample_Ready_I = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic fill(input logic half);
    Fill_Done_I = 1'b1;
    Fill_Half_I = half;
    step();
    Fill_Done_I = 1'b0;
    Fill_Half_I = 1'b0;
  endtask

  // Runs up to max_cyc cycles (or until stop_rel releases were seen) and
  // records pairs, releases and pulses.
  task automatic collect(input int max_cyc, input int stop_rel);
    c_pairs = 0; c_rel = 0; c_first_ren = -1; c_first_vld = -1;
    c_ovf = 0; c_udr = 0; c_ren = 0; c_first_addr = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (stop_rel > 0 && c_rel >= stop_rel) break;
      if (RAM_Ren_O) begin
        if (c_first_ren < 0) begin
          c_first_ren  = cyc;
          c_first_addr = RAM_Address_O;
        end
        c_ren++;
      end
      if (Sample_Valid_O && c_first_vld < 0) c_first_vld = cyc;
      if (Sample_Valid_O && Sample_Ready_I) begin
        if (c_pairs < 128) begin
          got_l[c_pairs] = Sample_Left_O;
          got_r[c_pairs] = Sample_Right_O;
        end
        c_pairs++;
      end
      if (Release_O) begin
        if (c_rel < 4) begin
          c_rel_half[c_rel] = Release_Half_O;
          c_rel_pair[c_rel] = c_pairs;
        end
        c_rel++;
      end
      if (Overflow_O) c_ovf++;
      if (Underrun_O) c_udr++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Fill_Done_I = 1'b1;
    Fill_Half_I = 1'b0;
    Sample_Ready_I = 1'b1;
    step();
    step();
    n_checks++;
    if ({Release_O, Release_Half_O, RAM_Ren_O, Sample_Valid_O, Overflow_O, Underrun_O} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rel=%b relh=%b ren=%b vld=%b ovf=%b udr=%b, expected all 0",
               Release_O, Release_Half_O, RAM_Ren_O, Sample_Valid_O, Overflow_O, Underrun_O);
    end
    n_checks++;
    if (RAM_Address_O !== 10'h0 || Sample_Left_O !== 16'h0 || Sample_Right_O !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h L=%h R=%h, expected 0", RAM_Address_O, Sample_Left_O, Sample_Right_O);
    end
    reset = 1'b0;
    Fill_Done_I = 1'b0;
    Sample_Ready_I = 1'b0;
    collect(20, 0);
    n_checks++;
    if (c_ren !== 0) begin
      n_fail++;
      $display("FAIL reset_fill_ignored: got %0d reads, expected 0", c_ren);
    end
  endtask

  task automatic test_single_half();
    logic [15:0] el;
    int bad;
    do_reset();
    Sample_Ready_I = 1'b1;
    fill(1'b0);
    collect(400, 1);
    n_checks++;
    if (c_rel !== 1 || c_pairs !== 32) begin
      n_fail++;
      $display("FAIL single_count: got rel=%0d pairs=%0d, expected 1 and 32", c_rel, c_pairs);
    end
    n_checks++;
    if (c_first_vld - c_first_ren !== 3 || c_first_ren !== 1) begin
      n_fail++;
      $display("FAIL single_latency: got ren@%0d vld@%0d, expected 1 and 4", c_first_ren, c_first_vld);
    end
    n_checks++;
    if (c_first_addr !== 10'h280) begin
      n_fail++;
      $display("FAIL single_addr: got %h, expected 280", c_first_addr);
    end
    n_checks++;
    if (got_l[0] !== 16'h1000 || got_r[0] !== 16'h1001 || got_l[31] !== 16'h103E || got_r[31] !== 16'h103F) begin
      n_fail++;
      $display("FAIL single_ends: got first %h/%h last %h/%h, expected 1000/1001 103e/103f",
               got_l[0], got_r[0], got_l[31], got_r[31]);
    end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      el = 16'(32'h1000 + 2 * k);
      if (got_l[k] !== el || got_r[k] !== el + 16'd1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL single_pairs: got %0d wrong pairs, expected 0", bad);
    end
    n_checks++;
    if (c_rel_half[0] !== 1'b0 || c_rel_pair[0] !== 32) begin
      n_fail++;
      $display("FAIL single_release: got half=%b after %0d pairs, expected 0 after 32", c_rel_half[0], c_rel_pair[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] el;
    int bad;
    do_reset();
    Sample_Ready_I = 1'b1;
    fill(1'b0);
    fill(1'b1);
    collect(700, 2);
    n_checks++;
    if (c_rel !== 2 || c_pairs !== 64) begin
      n_fail++;
      $display("FAIL b2b_count: got rel=%0d pairs=%0d, expected 2 and 64", c_rel, c_pairs);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      el = (k < 32) ? 16'(32'h1000 + 2 * k) : 16'(32'h2000 + 2 * (k - 32));
      if (got_l[k] !== el || got_r[k] !== el + 16'd1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_pairs: got %0d wrong pairs, expected 0", bad);
    end
    n_checks++;
    if (c_rel_half[0] !== 1'b0 || c_rel_half[1] !== 1'b1 || c_rel_pair[0] !== 32 || c_rel_pair[1] !== 64) begin
      n_fail++;
      $display("FAIL b2b_release: got halves %b,%b at %0d,%0d, expected 0,1 at 32,64",
               c_rel_half[0], c_rel_half[1], c_rel_pair[0], c_rel_pair[1]);
    end
    fill(1'b0);
    collect(40, 0);
    n_checks++;
    if (c_first_addr !== 10'h280 || got_l[0] !== 16'h1000) begin
      n_fail++;
      $display("FAIL b2b_wrap: got addr=%h L=%h, expected 280 and 1000", c_first_addr, got_l[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] l0, r0;
    int ren_cnt, unstable, waited;
    do_reset();
    fill(1'b0);
    waited = 0;
    while (!Sample_Valid_O && waited < 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (Sample_Valid_O !== 1'b1 || Sample_Left_O !== 16'h1000 || Sample_Right_O !== 16'h1001) begin
      n_fail++;
      $display("FAIL bp_first: got vld=%b L=%h R=%h, expected 1 1000 1001", Sample_Valid_O, Sample_Left_O, Sample_Right_O);
    end
    l0 = Sample_Left_O;
    r0 = Sample_Right_O;
    ren_cnt = 0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (RAM_Ren_O) ren_cnt++;
      if (Sample_Valid_O !== 1'b1 || Sample_Left_O !== l0 || Sample_Right_O !== r0) unstable++;
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles, expected 0", unstable);
    end
    n_checks++;
    if (ren_cnt !== 0) begin
      n_fail++;
      $display("FAIL bp_reads: got %0d reads while stalled, expected 0", ren_cnt);
    end
    Sample_Ready_I = 1'b1;
    step();
    Sample_Ready_I = 1'b0;
    n_checks++;
    if (Sample_Valid_O !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_clear: got vld=%b after handshake, expected 0", Sample_Valid_O);
    end
    waited = 0;
    while (!Sample_Valid_O && waited < 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (Sample_Valid_O !== 1'b1 || Sample_Left_O !== 16'h1002 || Sample_Right_O !== 16'h1003) begin
      n_fail++;
      $display("FAIL bp_next: got vld=%b L=%h R=%h, expected 1 1002 1003", Sample_Valid_O, Sample_Left_O, Sample_Right_O);
    end
  endtask

  task automatic test_underrun();
    int cnt;
    do_reset();
    Sample_Ready_I = 1'b1;
    fill(1'b0);
    collect(400, 1);
    Sample_Ready_I = 1'b0;
    n_checks++;
    if (c_rel !== 1) begin
      n_fail++;
      $display("FAIL udr_setup: got %0d releases, expected 1", c_rel);
    end
    cnt = 0;
    Sample_Ready_I = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (Underrun_O) cnt++;
    end
    Sample_Ready_I = 1'b0;
    step();
    n_checks++;
    if (cnt !== 5 || Underrun_O !== 1'b0) begin
      n_fail++;
      $display("FAIL udr_pulses: got %0d pulses, trailing=%b, expected 5 and 0", cnt, Underrun_O);
    end
    Sample_Ready_I = 1'b1;
    fill(1'b1);
    collect(40, 0);
    n_checks++;
    if (c_first_addr !== 10'h2C0 || got_l[0] !== 16'h2000 || got_r[0] !== 16'h2001) begin
      n_fail++;
      $display("FAIL udr_resume: got addr=%h L=%h R=%h, expected 2c0 2000 2001", c_first_addr, got_l[0], got_r[0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    Sample_Ready_I = 1'b1;
    fill(1'b0);
    fill(1'b0);
    collect(300, 0);
    n_checks++;
    if (c_ovf !== 1) begin
      n_fail++;
      $display("FAIL ovf_pulse: got %0d pulses, expected 1", c_ovf);
    end
    n_checks++;
    if (c_pairs !== 32 || c_rel !== 1) begin
      n_fail++;
      $display("FAIL ovf_pairs: got pairs=%0d rel=%0d, expected 32 and 1", c_pairs, c_rel);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    Sample_Ready_I = 1'b1;
    fill(1'b0);
    waited = 0;
    while (!(RAM_Ren_O && RAM_Address_O == 10'h285) && waited < 100) begin
      step();
      waited++;
    end
    n_checks++;
    if (RAM_Ren_O !== 1'b1 || RAM_Address_O !== 10'h285) begin
      n_fail++;
      $display("FAIL mid_reach: got ren=%b addr=%h, expected 1 285", RAM_Ren_O, RAM_Address_O);
    end
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({Release_O, Release_Half_O, RAM_Ren_O, Sample_Valid_O, Overflow_O, Underrun_O} !== 6'b0 ||
        RAM_Address_O !== 10'h0 || Sample_Left_O !== 16'h0 || Sample_Right_O !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_outputs: got ren=%b vld=%b addr=%h L=%h R=%h, expected all 0",
               RAM_Ren_O, Sample_Valid_O, RAM_Address_O, Sample_Left_O, Sample_Right_O);
    end
    reset = 1'b0;
    collect(20, 0);
    n_checks++;
    if (c_ren !== 0 || c_pairs !== 0) begin
      n_fail++;
      $display("FAIL mid_flags: got reads=%0d pairs=%0d, expected 0 and 0", c_ren, c_pairs);
    end
    fill(1'b0);
    collect(40, 0);
    n_checks++;
    if (c_first_addr !== 10'h280 || got_l[0] !== 16'h1000 || got_r[0] !== 16'h1001) begin
      n_fail++;
      $display("FAIL mid_restart: got addr=%h L=%h R=%h, expected 280 1000 1001", c_first_addr, got_l[0], got_r[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hBEEF;
    for (int n = 0; n < 64; n++) begin
      mem[10'h280 + n] = 16'(32'h1000 + n);
      mem[10'h2C0 + n] = 16'(32'h2000 + n);
    end
    reset = 1'b1;
    Fill_Done_I = 1'b0;
    Fill_Half_I = 1'b0;
    Sample_Ready_I = 1'b0;
    test_reset();
    test_single_half();
    test_back_to_back();
    test_backpressure();
    test_underrun();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_sample_reader.md
Name: pcm_sample_reader

Overview:
- Drain side of the decoder's 1024x16 sample buffer. The synthesis filterbank writes PCM words into a ping-pong region of that buffer; this block reads them back through its own read port.
- Interleaved L/R words are read out, assembled into stereo pairs and presented to the audio codec transmitter over a valid/ready handshake.
- A half is released back to the producer once it has been fully played.

Parameters:
- ADDR_W, 10, sample-buffer address width
- DATA_W, 16, PCM word width
- BUF_BASE, 10'h280, first word of ping-pong region
- HALF_LEN, 64, words per half (32 L/R pairs); must be even and a power of two

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Fill_Done_I  in  1  one-cycle pulse: producer finished writing a half
- Fill_Half_I  in  1  half index qualified by Fill_Done_I
- Release_O  out  1  one-cycle pulse: half fully consumed, free for refill
- Release_Half_O  out  1  half index qualified by Release_O
- RAM_Address_O  out  ADDR_W  read address
- RAM_Ren_O  out  1  read enable
- RAM_Data_I  in  DATA_W  read data, valid one cycle after the address
- Sample_Left_O  out  DATA_W  left PCM sample
- Sample_Right_O  out  DATA_W  right PCM sample
- Sample_Valid_O  out  1  stereo pair valid
- Sample_Ready_I  in  1  transmitter accepts pair
- Overflow_O  out  1  pulse: fill of a half already marked full
- Underrun_O  out  1  pulse: transmitter ready while no data, after first playback

Behaviour:
- Reset (synchronous, active-high; wins over all inputs, including mid-read): every output is 0. Half-full flags are 00, play_half is 0, pair index is 0, started flag is 0, FSM goes to IDLE.
- Half-full flags: Fill_Done_I sets full[Fill_Half_I].
  - If that flag is already set, Overflow_O pulses and the flag stays set.
  - If a set and a release hit the same half in the same cycle, the set wins.
- Address: BUF_BASE + play_half*HALF_LEN + 2*idx (+1 for the right sample). Computed in ADDR_W bits; wrap is not permitted by the parameter choice.
- FSM states:
  - IDLE: if full[play_half], go to RD_L. Otherwise, if started and Sample_Ready_I, pulse Underrun_O.
  - RD_L: drive the L address with RAM_Ren_O=1 -> RD_R.
  - RD_R: drive the R address with RAM_Ren_O=1; capture RAM_Data_I into the left holding register -> CAP_R.
  - CAP_R: capture RAM_Data_I into the right register; RAM_Ren_O=0; update Sample_Left_O and Sample_Right_O; set Sample_Valid_O -> PRESENT.
  - PRESENT: hold outputs stable while Sample_Valid_O && !Sample_Ready_I. On the handshake, clear Sample_Valid_O and set started. Then:
    - if idx == HALF_LEN/2-1: go to RELEASE;
    - else: idx++ and go to RD_L.
  - RELEASE: pulse Release_O with Release_Half_O=play_half; clear full[play_half]; toggle play_half; set idx=0 -> IDLE.
- Latency: entering RD_L to Sample_Valid_O=1 is 3 cycles. Peak throughput is 1 pair per 4 cycles, far above the audio rate.
- Sample_Valid_O never deasserts without a handshake; data is stable while valid.
- RAM_Ren_O is asserted only in RD_L and RD_R. RAM_Address_O holds its last value otherwise.
- Underrun does not advance any pointer. Playback resumes in order once the half is filled.

Decomposition:
- Shared package `mp2_audio_pkg`:
  - FSM state encoding (IDLE, RD_L, RD_R, CAP_R, PRESENT, RELEASE);
  - constants SAMPLE_BUF_BASE and SAMPLE_HALF_LEN, also used by the filterbank writer.
- No sub-module is needed. The flag/overflow logic stays inline; the block is a single FSM with a datapath, about 200 lines.

Test Plan:
- Reset, then Fill_Done_I with half 0 (RAM words 0x280..0x2BF = 0x1000+n), Sample_Ready_I=1 -> 32 pairs, the first being L=0x1000 R=0x1001 and the last L=0x103E R=0x103F; 3-cycle first latency; Release_O with half 0 after the last pair.
- Fill half 0 and half 1 back to back, with half 1 words 0x2C0.. = 0x2000+n -> 64 contiguous pairs; the second release carries Release_Half_O=1; play_half returns to 0.
- Sample_Ready_I held 0 for 10 cycles during PRESENT -> Sample_Valid_O stays 1 and L/R stay unchanged; no RAM reads occur.
- After the first half is played with nothing pending, Sample_Ready_I=1 for 5 cycles -> 5 Underrun_O pulses; a later fill resumes at base 0x2C0.
- Fill_Done_I for half 0 twice with no release between -> one Overflow_O pulse; only 32 pairs are played.
- Assert reset in CAP_R mid-half -> all outputs 0 the next cycle; the flags are cleared; a new fill plays from 0x280.
